// File: rtl/ahsqr_pkg.sv
// Shared types and constants for the AHSQR square-reconstruction stage.
package ahsqr_pkg;

  localparam int unsigned ROOT_W_DEF = 8;
  localparam int unsigned SQ_W_DEF   = 2 * ROOT_W_DEF;

  // Counter width for ROOT_W iterations (at least one bit).
  function automatic int unsigned iter_w(input int unsigned root_w);
    return (root_w > 1) ? $clog2(root_w) : 1;
  endfunction

  localparam int unsigned ITER_W_DEF = iter_w(ROOT_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } recon_state_t;

  typedef logic [SQ_W_DEF-1:0] sq_t;

endpackage

// File: rtl/ahsqr_shift_add_step.sv
// One combinational shift-add multiply iteration: conditional add, then shift operands.
module ahsqr_shift_add_step #(
  parameter int unsigned ROOT_W = 8
) (
  input  logic [2*ROOT_W-1:0] acc_i,
  input  logic [2*ROOT_W-1:0] mcand_i,
  input  logic [ROOT_W-1:0]   mplier_i,
  output logic [2*ROOT_W-1:0] acc_c_o,
  output logic [2*ROOT_W-1:0] mcand_c_o,
  output logic [ROOT_W-1:0]   mplier_c_o
);

  assign acc_c_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_c_o  = mcand_i << 1;
  assign mplier_c_o = mplier_i >> 1;

endmodule

// File: rtl/ahsqr_square_reconstruct.sv
// Sequential q*q reconstruction with valid/ready handshakes; one transaction at a time.
// Optional R - q*q error / overshoot outputs are built when AHSQR_RECON_ERR_EN is defined.
module ahsqr_square_reconstruct
  import ahsqr_pkg::*;
#(
  parameter int unsigned ROOT_W = ROOT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ROOT_W-1:0]     in_root_i,
  input  logic [2*ROOT_W-1:0]   in_radicand_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
`ifdef AHSQR_RECON_ERR_EN
  output logic [2*ROOT_W:0]     out_err_o,
  output logic                  out_over_o,
`endif
  output logic [2*ROOT_W-1:0]   out_square_o
);

  localparam int unsigned SQ_W  = 2 * ROOT_W;
  localparam int unsigned CNT_W = iter_w(ROOT_W);

  recon_state_t      state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SQ_W-1:0]   acc_q, acc_d;
  logic [SQ_W-1:0]   mcand_q, mcand_d;
  logic [ROOT_W-1:0] mplier_q, mplier_d;
  logic [SQ_W-1:0]   square_q, square_d;
  logic              valid_q, valid_d;
  logic              in_ready_q, in_ready_d;

  logic [SQ_W-1:0]   step_acc;
  logic [SQ_W-1:0]   step_mcand;
  logic [ROOT_W-1:0] step_mplier;

`ifdef AHSQR_RECON_ERR_EN
  logic [SQ_W-1:0]   rad_q, rad_d;
  logic [SQ_W:0]     err_q, err_d;
  logic              over_q, over_d;
  logic [SQ_W:0]     diff;

  // Both operands are non-negative and fit in SQ_W bits, so the extra MSB is the sign.
  assign diff = {1'b0, rad_q} - {1'b0, step_acc};
`else
  logic unused_radicand;
  assign unused_radicand = ^in_radicand_i;
`endif

  ahsqr_shift_add_step #(.ROOT_W(ROOT_W)) u_step (
    .acc_i      (acc_q),
    .mcand_i    (mcand_q),
    .mplier_i   (mplier_q),
    .acc_c_o    (step_acc),
    .mcand_c_o  (step_mcand),
    .mplier_c_o (step_mplier)
  );

  // State, operand and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      square_q   <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef AHSQR_RECON_ERR_EN
      rad_q      <= '0;
      err_q      <= '0;
      over_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      square_q   <= square_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
`ifdef AHSQR_RECON_ERR_EN
      rad_q      <= rad_d;
      err_q      <= err_d;
      over_q     <= over_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    square_d = square_q;
    valid_d  = valid_q;
`ifdef AHSQR_RECON_ERR_EN
    rad_d    = rad_q;
    err_d    = err_q;
    over_d   = over_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          mcand_d  = SQ_W'(in_root_i);
          mplier_d = in_root_i;
          acc_d    = '0;
          count_d  = '0;
`ifdef AHSQR_RECON_ERR_EN
          rad_d    = in_radicand_i;
`endif
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ROOT_W - 1)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          square_d = step_acc;
`ifdef AHSQR_RECON_ERR_EN
          err_d    = diff;
          over_d   = diff[SQ_W];
`endif
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = valid_q;
  assign out_square_o = square_q;
`ifdef AHSQR_RECON_ERR_EN
  assign out_err_o    = err_q;
  assign out_over_o   = over_q;
`endif

endmodule

// File: tb/tb_ahsqr_square_reconstruct.sv
// Self-checking bench: directed vector table, reset/stall sequences, random traffic vs q*q model.
module tb_ahsqr_square_reconstruct;
  import ahsqr_pkg::*;

  localparam int unsigned RW = ROOT_W_DEF;
  localparam int unsigned SW = 2 * RW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [RW-1:0] in_root_i = '0;
  sq_t           in_radicand_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  sq_t           out_square_o;
`ifdef AHSQR_RECON_ERR_EN
  logic [SW:0]   out_err_o;
  logic          out_over_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahsqr_square_reconstruct #(.ROOT_W(RW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_root_i     (in_root_i),
    .in_radicand_i (in_radicand_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
`ifdef AHSQR_RECON_ERR_EN
    .out_err_o     (out_err_o),
    .out_over_o    (out_over_o),
`endif
    .out_square_o  (out_square_o)
  );

  typedef struct {
    int unsigned q;
    int unsigned r;
    int          stall;
    bit          extra;
    int unsigned exp_sq;
    int          exp_err;
    bit          exp_over;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int unsigned q, input int unsigned r, input int stall, input bit extra,
                         input int unsigned exp_sq, input int exp_err, input bit exp_over);
    int n;
    logic [SW:0] err_exp;
    err_exp = (SW+1)'(exp_err);
    n = 0;
    while (!in_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 32'(in_ready_o), 32'd1);
    in_valid_i    = 1'b1;
    in_root_i     = RW'(q);
    in_radicand_i = SW'(r);
    tick();
    in_valid_i    = 1'b0;
    in_root_i     = RW'($urandom);
    in_radicand_i = SW'($urandom);
    n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    chk("square", 32'(out_square_o), 32'(exp_sq));
`ifdef AHSQR_RECON_ERR_EN
    chk("err", 32'(out_err_o), 32'(err_exp));
    chk("over", 32'(out_over_o), 32'(exp_over));
`endif
    for (int i = 0; i < stall; i++) begin
      if (extra) begin
        in_valid_i = 1'b1;
        in_root_i  = RW'(99);
      end
      tick();
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_square", 32'(out_square_o), 32'(exp_sq));
      chk("hold_in_ready", 32'(in_ready_o), 32'd0);
`ifdef AHSQR_RECON_ERR_EN
      chk("hold_err", 32'(out_err_o), 32'(err_exp));
`endif
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("post_valid", 32'(out_valid_o), 32'd0);
    chk("post_in_ready", 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    int unsigned q, r, sq;
    int seen;

    vecs[0] = '{q: 0,   r: 0,     stall: 0, extra: 0, exp_sq: 0,     exp_err: 0,   exp_over: 0};
    vecs[1] = '{q: 255, r: 65535, stall: 0, extra: 0, exp_sq: 65025, exp_err: 510, exp_over: 0};
    vecs[2] = '{q: 16,  r: 250,   stall: 1, extra: 0, exp_sq: 256,   exp_err: -6,  exp_over: 1};
    vecs[3] = '{q: 13,  r: 170,   stall: 5, extra: 1, exp_sq: 169,   exp_err: 1,   exp_over: 0};
    vecs[4] = '{q: 128, r: 16384, stall: 2, extra: 0, exp_sq: 16384, exp_err: 0,   exp_over: 0};
    vecs[5] = '{q: 255, r: 0,     stall: 0, extra: 0, exp_sq: 65025, exp_err: -65025, exp_over: 1};

    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_square", 32'(out_square_o), 32'd0);
`ifdef AHSQR_RECON_ERR_EN
    chk("rst_err", 32'(out_err_o), 32'd0);
    chk("rst_over", 32'(out_over_o), 32'd0);
`endif

    foreach (vecs[i])
      run_txn(vecs[i].q, vecs[i].r, vecs[i].stall, vecs[i].extra,
              vecs[i].exp_sq, vecs[i].exp_err, vecs[i].exp_over);

    // The in_valid offered during the stall must not have started a transaction.
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_o) seen++;
    end
    chk("no_phantom_txn", 32'(seen), 32'd0);

    // Reset in the middle of BUSY discards the transaction.
    in_valid_i    = 1'b1;
    in_root_i     = RW'(200);
    in_radicand_i = SW'(40000);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_square", 32'(out_square_o), 32'd0);
`ifdef AHSQR_RECON_ERR_EN
    chk("midrst_err", 32'(out_err_o), 32'd0);
    chk("midrst_over", 32'(out_over_o), 32'd0);
`endif
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_o) seen++;
    end
    chk("midrst_no_partial", 32'(seen), 32'd0);
    run_txn(3, 9, 0, 0, 9, 0, 0);

    // Reset while holding a result in DONE.
    in_valid_i    = 1'b1;
    in_root_i     = RW'(7);
    in_radicand_i = SW'(50);
    tick();
    in_valid_i = 1'b0;
    repeat (10) tick();
    chk("done_before_rst", 32'(out_valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("donerst_out_valid", 32'(out_valid_o), 32'd0);
    chk("donerst_square", 32'(out_square_o), 32'd0);
    chk("donerst_in_ready", 32'(in_ready_o), 32'd1);

    // Random traffic against plain-arithmetic model.
    for (int t = 0; t < 1000; t++) begin
      q  = $urandom_range(255, 0);
      r  = $urandom_range(65535, 0);
      sq = q * q;
      repeat ($urandom_range(2, 0)) tick();
      run_txn(q, r, $urandom_range(3, 0), 1'b0, sq, int'(r) - int'(sq), sq > r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  localparam int unsigned CHK_ITER_W = ITER_W_DEF;
  initial begin
    if (CHK_ITER_W != 3) $display("note: iteration counter width %0d", CHK_ITER_W);
  end

endmodule
